// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared types for the five-stage MIPS core. It holds the word,
//             register-index and ALU-op types and the ID/EX latch record.
//             It also defines the bubble constant and the halt FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [3:0]  aluop_t;

    // Everything the ID/EX register latches, apart from the valid flag.
    typedef struct packed {
        regbits_t rs;
        regbits_t rt;
        regbits_t wsel;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        word_t    pcp4;
        aluop_t   aluop;
        logic     alusrc;
        logic     RegWr;
        logic     dREN;
        logic     dWEN;
        logic     lui;
        logic     halt;
    } id_ex_t;

    // In a bubble, every side-effecting control bit is 0 and wsel is 0.
    // The data fields are don't-care and are zeroed for determinism.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_if
//  Purpose  : Signal bundle around the ID/EX pipeline register.
//             Modports:
//               idex - the register itself (ID side in, EX side out)
//               ex   - execute stage / forwarding unit (EX side in)
//               tb   - stimulus and observation
//  Revision : 1.0 - initial release
// ============================================================================
interface id_ex_if
    import cpu_types_pkg::*;
(
    input logic CLK
);
    logic        nRST;
    logic [4:0]  id_rs, id_rt, id_wsel;
    logic [31:0] id_rdat1, id_rdat2, id_imm, id_pcp4;
    logic [3:0]  id_aluop;
    logic        id_alusrc, id_RegWr, id_dREN, id_dWEN, id_lui, id_halt;
    logic        wb_RegWr;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        mem_hold, flush;
    logic [4:0]  ex_rs, ex_rt, ex_wsel;
    logic [31:0] ex_rdat1, ex_rdat2, ex_imm, ex_pcp4;
    logic [3:0]  ex_aluop;
    logic        ex_alusrc, ex_RegWr, ex_dREN, ex_dWEN, ex_lui, ex_halt;
    logic        ex_valid, stall_id, halted;
    logic [15:0] bubble_cnt;

    modport idex (
        input  CLK, nRST,
        input  id_rs, id_rt, id_wsel, id_rdat1, id_rdat2, id_imm, id_pcp4,
        input  id_aluop, id_alusrc, id_RegWr, id_dREN, id_dWEN, id_lui, id_halt,
        input  wb_RegWr, wb_wsel, wb_wdat, mem_hold, flush,
        output ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_pcp4,
        output ex_aluop, ex_alusrc, ex_RegWr, ex_dREN, ex_dWEN, ex_lui, ex_halt,
        output ex_valid, stall_id, halted, bubble_cnt
    );

    modport ex (
        input  CLK,
        input  ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_pcp4,
        input  ex_aluop, ex_alusrc, ex_RegWr, ex_dREN, ex_dWEN, ex_lui, ex_halt,
        input  ex_valid, halted
    );

    modport tb (
        input  CLK,
        output nRST,
        output id_rs, id_rt, id_wsel, id_rdat1, id_rdat2, id_imm, id_pcp4,
        output id_aluop, id_alusrc, id_RegWr, id_dREN, id_dWEN, id_lui, id_halt,
        output wb_RegWr, wb_wsel, wb_wdat, mem_hold, flush,
        input  ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_pcp4,
        input  ex_aluop, ex_alusrc, ex_RegWr, ex_dREN, ex_dWEN, ex_lui, ex_halt,
        input  ex_valid, stall_id, halted, bubble_cnt
    );

endinterface
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Purpose  : Combinational load-use hazard detector. It flags the case where
//             the instruction in EX is a live load and the instruction in ID
//             reads that load's destination register.
//  Ports    : i_ex_valid, i_ex_dren, i_ex_wsel - EX slot state
//             i_id_rs, i_id_rt                 - ID source registers
//             o_luh                            - hazard present
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_dren,
    input  logic [4:0] i_ex_wsel,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_luh
);
    logic w_load_live;
    logic w_src_match;

    // r0 is hard-wired to zero, so a load targeting it never produces data
    // that anyone has to wait for.
    assign w_load_live = i_ex_valid & i_ex_dren & (i_ex_wsel != 5'd0);
    assign w_src_match = (i_ex_wsel == i_id_rs) | (i_ex_wsel == i_id_rt);
    assign o_luh       = w_load_live & w_src_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_reg
//  Purpose  : ID/EX pipeline register with load-use hazard detection.
//             On each edge it either holds (mem_hold), loads a bubble
//             (flush, load-use or halted), or captures the decoded
//             instruction. It also tracks a sticky halt and counts bubbles.
//  Ports    : CLK, nRST          - clock, synchronous active-low reset
//             id_*               - decoded fields from ID
//             wb_*               - write-back port (bypass build only)
//             mem_hold, flush    - MEM stall, taken branch/jump
//             ex_*, ex_valid     - registered EX slot
//             stall_id           - combinational PC / IF-ID freeze
//             halted, bubble_cnt - status
//  Config   : IDEX_WB_BYPASS_EN - when defined, a same-cycle write-back to
//             rs/rt replaces the register-file read data on capture
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_wsel,
    input  logic [31:0] id_rdat1,
    input  logic [31:0] id_rdat2,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pcp4,
    input  logic [3:0]  id_aluop,
    input  logic        id_alusrc,
    input  logic        id_RegWr,
    input  logic        id_dREN,
    input  logic        id_dWEN,
    input  logic        id_lui,
    input  logic        id_halt,
    input  logic        wb_RegWr,
    input  logic [4:0]  wb_wsel,
    input  logic [31:0] wb_wdat,
    input  logic        mem_hold,
    input  logic        flush,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_wsel,
    output logic [31:0] ex_rdat1,
    output logic [31:0] ex_rdat2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pcp4,
    output logic [3:0]  ex_aluop,
    output logic        ex_alusrc,
    output logic        ex_RegWr,
    output logic        ex_dREN,
    output logic        ex_dWEN,
    output logic        ex_lui,
    output logic        ex_halt,
    output logic        ex_valid,
    output logic        stall_id,
    output logic        halted,
    output logic [15:0] bubble_cnt
);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    id_ex_t      r_ex;
    logic        r_valid;
    halt_state_t r_state;
    halt_state_t w_state_nxt;
    logic [15:0] r_bubble_cnt;

    id_ex_t      w_id;
    logic [31:0] w_rdat1;
    logic [31:0] w_rdat2;
    logic        w_luh;
    logic        w_halted;
    logic        w_bubble;
    logic        w_capture;

`ifdef IDEX_WB_BYPASS_EN
    // The register file does not forward a write to a same-cycle read,
    // so pick up the write-back value here instead.
    logic w_wb_live;
    assign w_wb_live = wb_RegWr & (wb_wsel != 5'd0);
    assign w_rdat1   = (w_wb_live && (wb_wsel == id_rs)) ? wb_wdat : id_rdat1;
    assign w_rdat2   = (w_wb_live && (wb_wsel == id_rt)) ? wb_wdat : id_rdat2;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_RegWr, wb_wsel, wb_wdat};
    assign w_rdat1     = id_rdat1;
    assign w_rdat2     = id_rdat2;
`endif

    always_comb begin
        w_id        = ID_EX_BUBBLE;
        w_id.rs     = id_rs;
        w_id.rt     = id_rt;
        w_id.wsel   = id_wsel;
        w_id.rdat1  = w_rdat1;
        w_id.rdat2  = w_rdat2;
        w_id.imm    = id_imm;
        w_id.pcp4   = id_pcp4;
        w_id.aluop  = id_aluop;
        w_id.alusrc = id_alusrc;
        w_id.RegWr  = id_RegWr;
        w_id.dREN   = id_dREN;
        w_id.dWEN   = id_dWEN;
        w_id.lui    = id_lui;
        w_id.halt   = id_halt;
    end

    load_use_detect u_load_use_detect (
        .i_ex_valid (r_valid),
        .i_ex_dren  (r_ex.dREN),
        .i_ex_wsel  (r_ex.wsel),
        .i_id_rs    (id_rs),
        .i_id_rt    (id_rt),
        .o_luh      (w_luh)
    );

    assign w_halted  = (r_state == HALTED);
    assign w_bubble  = ~mem_hold & (flush | w_luh | w_halted);
    assign w_capture = ~mem_hold & ~flush & ~w_luh & ~w_halted;

    // A flush discards the wrong-path instruction in ID, so there is no point
    // stalling it for a load-use hazard that will never execute.
    assign stall_id  = (w_luh & ~flush) | mem_hold;

    // EX slot: with mem_hold set, neither branch fires and contents hold.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ex    <= ID_EX_BUBBLE;
            r_valid <= 1'b0;
        end else if (w_bubble) begin
            r_ex    <= ID_EX_BUBBLE;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_ex    <= w_id;
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The halt instruction itself is captured on the same edge that moves
    // the FSM to HALTED, so it still reaches EX.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_capture && id_halt) w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign ex_rs      = r_ex.rs;
    assign ex_rt      = r_ex.rt;
    assign ex_wsel    = r_ex.wsel;
    assign ex_rdat1   = r_ex.rdat1;
    assign ex_rdat2   = r_ex.rdat2;
    assign ex_imm     = r_ex.imm;
    assign ex_pcp4    = r_ex.pcp4;
    assign ex_aluop   = r_ex.aluop;
    assign ex_alusrc  = r_ex.alusrc;
    assign ex_RegWr   = r_ex.RegWr;
    assign ex_dREN    = r_ex.dREN;
    assign ex_dWEN    = r_ex.dWEN;
    assign ex_lui     = r_ex.lui;
    assign ex_halt    = r_ex.halt;
    assign ex_valid   = r_valid;
    assign halted     = w_halted;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire
